mlaccel_banked_memory: RTL and testbench

//  Parametrised successor to the 4x16-bit SPRAM memory: NBANKS interleaved banks of DW-bit words.

---
 rtl/mlaccel_banked_memory.sv | 174 +++++++++++++++++
 tb/tb_mlaccel_banked_memory.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mlaccel_banked_memory.sv
`default_nettype none
// ============================================================================
// Module   : mlaccel_banked_memory
// Purpose  : NBANKS interleaved banks of DW-bit words. A read beat returns
//            NBANKS consecutive words starting at any word address. Reads
//            are strided bursts. Writes are single words with byte strobes.
//            Word w lives in bank w%NBANKS, row w/NBANKS.
// Ports    : clock, resetn (sync, active-low)
//            req_valid/req_ready handshake; req_write selects write or read
//            req_addr, req_len (beats-1), req_stride, req_wstrb, req_wdata
//            rsp_valid/rsp_last/rsp_data: read vector, 2 cycles after issue
//            busy: burst in progress or responses still in the pipeline
// Revision : 1.0  initial release
// ============================================================================
module mlaccel_banked_memory #(
    parameter int NBANKS = 4,
    parameter int DW     = 16,
    parameter int AW     = 16,
    parameter int LENW   = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [AW-1:0]        req_addr,
    input  logic [LENW-1:0]      req_len,
    input  logic [AW-1:0]        req_stride,
    input  logic [DW/8-1:0]      req_wstrb,
    input  logic [DW-1:0]        req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_last,
    output logic [NBANKS*DW-1:0] rsp_data,
    output logic                 busy
);
    localparam int c_BW    = $clog2(NBANKS);
    localparam int c_RW    = AW - c_BW;
    localparam int c_NLANE = DW / 8;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;

    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   r_stride;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_cnt;

    logic            w_acc;
    logic            w_wr_en;
    logic            w_rd_start;
    logic            w_issue;
    logic            w_issue_last;
    logic [AW-1:0]   w_issue_addr;
    logic [c_BW-1:0] w_issue_bank;
    logic [c_RW-1:0] w_row0;
    logic [c_RW-1:0] w_row1;
    logic [c_BW-1:0] w_wr_bank;
    logic [c_RW-1:0] w_wr_row;

    logic [DW-1:0]   w_bank_q [NBANKS];
    logic            r_s1_valid;
    logic            r_s1_last;
    logic [c_BW-1:0] r_s1_rot;
    logic [NBANKS*DW-1:0] w_rot;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_rd_start && (req_len != '0)) w_state_nxt = c_BURST;
            c_BURST: if (r_cnt == r_len)                 w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = (r_state == c_IDLE);
        busy      = (r_state == c_BURST) | r_s1_valid | rsp_valid;
    end

    // Request decode. Side effects are gated with resetn so nothing lands
    // in memory or the pipeline on a reset edge.
    assign w_acc      = req_valid & req_ready;
    assign w_wr_en    = resetn & w_acc & req_write;
    assign w_rd_start = resetn & w_acc & ~req_write;

    // Beat 0 issues in the acceptance cycle straight from the request; the
    // remaining beats come from the latched burst registers.
    assign w_issue      = w_rd_start | (resetn & (r_state == c_BURST));
    assign w_issue_addr = (r_state == c_BURST) ? r_addr : req_addr;
    assign w_issue_last = (r_state == c_BURST) ? (r_cnt == r_len) : (req_len == '0);
    assign w_issue_bank = w_issue_addr[c_BW-1:0];
    assign w_row0       = w_issue_addr[AW-1:c_BW];
    assign w_row1       = w_row0 + c_RW'(1);   // wraps top row to row 0

    assign w_wr_bank = req_addr[c_BW-1:0];
    assign w_wr_row  = req_addr[AW-1:c_BW];

    // ---------------- Burst bookkeeping ----------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_addr   <= '0;
            r_stride <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
        end else if (w_rd_start) begin
            r_addr   <= req_addr + req_stride;
            r_stride <= req_stride;
            r_len    <= req_len;
            r_cnt    <= LENW'(1);
        end else if (r_state == c_BURST) begin
            r_addr   <= r_addr + r_stride;
            r_cnt    <= r_cnt + LENW'(1);
        end
    end

    // ---------------- Banks ----------------
    // Banks below the start bank hold the words that spill into the next row.
    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [DW-1:0]   r_mem [2**c_RW];
        logic [DW-1:0]   r_q;
        logic [c_RW-1:0] w_rd_row;

        assign w_rd_row    = (c_BW'(b) < w_issue_bank) ? w_row1 : w_row0;
        assign w_bank_q[b] = r_q;

        always_ff @(posedge clock) begin
            if (w_wr_en && (w_wr_bank == c_BW'(b))) begin
                for (int l = 0; l < c_NLANE; l++) begin
                    if (req_wstrb[l]) r_mem[w_wr_row][l*8 +: 8] <= req_wdata[l*8 +: 8];
                end
            end
            if (w_issue) r_q <= r_mem[w_rd_row];
        end
    end

    // Rotate right by the start bank so word addr+k lands in lane k.
    for (genvar k = 0; k < NBANKS; k++) begin : g_rot
        assign w_rot[k*DW +: DW] = w_bank_q[c_BW'(k) + r_s1_rot];
    end

    // ---------------- Response pipeline ----------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_rot   <= '0;
            rsp_valid  <= 1'b0;
            rsp_last   <= 1'b0;
            rsp_data   <= '0;
        end else begin
            r_s1_valid <= w_issue;
            r_s1_last  <= w_issue & w_issue_last;
            r_s1_rot   <= w_issue_bank;
            rsp_valid  <= r_s1_valid;
            rsp_last   <= r_s1_valid & r_s1_last;
            if (r_s1_valid) rsp_data <= w_rot;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mlaccel_banked_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlaccel_banked_memory
// Purpose  : Self-checking bench for mlaccel_banked_memory (4 x 16-bit banks,
//            8-bit word address). Keeps a flat word-array model of memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_mlaccel_banked_memory;
    localparam int NBANKS = 4;
    localparam int DW     = 16;
    localparam int AW     = 8;
    localparam int LENW   = 8;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [AW-1:0]        req_addr;
    logic [LENW-1:0]      req_len;
    logic [AW-1:0]        req_stride;
    logic [DW/8-1:0]      req_wstrb;
    logic [DW-1:0]        req_wdata;
    logic                 rsp_valid;
    logic                 rsp_last;
    logic [NBANKS*DW-1:0] rsp_data;
    logic                 busy;

    logic [15:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    mlaccel_banked_memory #(.NBANKS(NBANKS), .DW(DW), .AW(AW), .LENW(LENW)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_stride (req_stride),
        .req_wstrb  (req_wstrb),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_last   (rsp_last),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Four consecutive words from the model, address wrapping mod 256.
    function automatic logic [63:0] vec(input logic [7:0] a);
        logic [63:0] v;
        logic [7:0]  w;
        for (int k = 0; k < 4; k++) begin
            w = a + 8'(k);
            v[k*16 +: 16] = mem[w];
        end
        return v;
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [1:0] strb, input logic [15:0] d);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wstrb = strb; req_wdata = d;
        check("wr_ready", 64'(req_ready), 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0; req_write = 1'b0;
        for (int l = 0; l < 2; l++) if (strb[l]) mem[a][l*8 +: 8] = d[l*8 +: 8];
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] len,
                           input logic [7:0] stride);
        logic [7:0]  ba;
        logic [63:0] last_vec;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len; req_stride = stride;
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        check({tag, "_nolat1"}, 64'(rsp_valid), 64'd0);
        last_vec = '0;
        for (int i = 0; i <= int'(len); i++) begin
            @(posedge clock); #1;
            ba = a + 8'(i) * stride;
            last_vec = vec(ba);
            check($sformatf("%s_v%0d", tag, i), 64'(rsp_valid), 64'd1);
            check($sformatf("%s_d%0d", tag, i), rsp_data, last_vec);
            check($sformatf("%s_l%0d", tag, i), 64'(rsp_last), 64'(i == int'(len)));
            check($sformatf("%s_r%0d", tag, i), 64'(req_ready), 64'((i + 1) >= int'(len)));
        end
        @(posedge clock); #1;
        check({tag, "_end_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_end_busy"},  64'(busy), 64'd0);
        check({tag, "_hold"},      rsp_data, last_vec);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] old_vec;
        int nv;
        resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_stride = '0; req_wstrb = '0; req_wdata = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_last",  64'(rsp_last), 64'd0);
        check("rst_data",  rsp_data, 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        resetn = 1'b1;
        check("rst_ready", 64'(req_ready), 64'd1);

        // Fill memory with 0x1000+i
        for (int i = 0; i < 256; i++) do_write(8'(i), 2'b11, 16'h1000 + 16'(i));

        // Unaligned single reads, including address/row wrap
        do_read("rd5", 8'd5, 8'd0, 8'd1);
        check("rd5_const", rsp_data, 64'h1008_1007_1006_1005);
        do_read("rdFE", 8'hFE, 8'd0, 8'd1);
        check("rdFE_const", rsp_data, 64'h1001_1000_10FF_10FE);

        // Strided burst
        do_read("burst", 8'd2, 8'd3, 8'd4);
        check("burst_const", rsp_data[15:0], 64'h100E);

        // Byte-lane write, then zero-strobe no-op
        do_write(8'd9, 2'b01, 16'hAB55);
        do_read("strb01", 8'd9, 8'd0, 8'd1);
        check("strb01_word", 64'(rsp_data[15:0]), 64'h1055);
        do_write(8'd9, 2'b00, 16'hFFFF);
        do_read("strb00", 8'd9, 8'd0, 8'd1);
        check("strb00_word", 64'(rsp_data[15:0]), 64'h1055);

        // Reset in the middle of a len=7 burst, while beat 3 is issuing
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd40; req_len = 8'd7; req_stride = 8'd1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        check("abort_d0", rsp_data, vec(8'd40));
        @(posedge clock); #1;
        check("abort_d1", rsp_data, vec(8'd41));
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        check("abort_valid", 64'(rsp_valid), 64'd0);
        check("abort_busy",  64'(busy), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (rsp_valid) nv++;
        end
        check("abort_no_beats", 64'(nv), 64'd0);
        do_read("abort_mem", 8'd40, 8'd7, 8'd1);

        // Read at 20 then write at 21 on the very next cycle
        old_vec = vec(8'd20);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd20; req_len = 8'd0; req_stride = 8'd1;
        @(posedge clock); #1;
        req_write = 1'b1; req_addr = 8'd21; req_wstrb = 2'b11; req_wdata = 16'h5A5A;
        check("order_ready", 64'(req_ready), 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0; req_write = 1'b0;
        mem[21] = 16'h5A5A;
        check("order_valid", 64'(rsp_valid), 64'd1);
        check("order_old",   rsp_data, old_vec);
        @(posedge clock); #1;
        do_read("order_new", 8'd20, 8'd0, 8'd1);

        // Randomized mix of writes and strided bursts against the model
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_write(8'($urandom), 2'($urandom), 16'($urandom));
            end else begin
                do_read($sformatf("rnd%0d", t), 8'($urandom), 8'($urandom_range(0, 5)),
                        8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
